xorshift_prng_bank: RTL
=======================

# xorshift_prng_bank

Multi-channel, parametrised xorshift pseudo-random number generator for the ray-tracing datapath. It supplies independent random streams to several consumers, for example per-lane jitter or sampling. Each channel has a valid/ready output handshake and advances only when its value is consumed. A shared reseed port and a post-reset warm-up phase discard the weak early outputs.

## Interface
- `NUM_CH`, 4, number of independent channels (≥1)
- `STATE_W`, 16, xorshift state width; only 16 or 32 are legal
- `OUT_W`, 12, output width; the output is the top `OUT_W` bits of the state (1 ≤ `OUT_W` ≤ `STATE_W`)
- `SEED`, 16'h1ACE (zero-extended to `STATE_W`), base seed; must be nonzero
- `WARMUP`, 8, number of free-running steps after reset before outputs become valid (0 allowed)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `out_valid` out `NUM_CH`: channel *i* has a value available
- `out_ready` in `NUM_CH`: consumer *i* accepts the value
- `out_data` out `NUM_CH*OUT_W`: flat vector; channel *i* is at bits [i*OUT_W +: OUT_W]
- `reseed_valid` in 1: reseed request
- `reseed_ready` out 1: reseed can be accepted
- `reseed_ch` in max(1,$clog2(NUM_CH)): target channel
- `reseed_value` in `STATE_W`: new state

## Operation
- Per-channel default seed: `SEED ^ (i * GOLD)`.
  - `GOLD` = 16'h9E37 when `STATE_W`=16, and 32'h9E3779B9 when `STATE_W`=32.
  - A zero result is replaced with 1.
  - Channel 0 default = `SEED`.
- Next-state function:
  - t = s ^ (s >> A)
  - t2 = t ^ (t << B)
  - n = t2 ^ (t2 >> C)
  - All shifts are logical and truncated to `STATE_W`.
  - (A,B,C) = (7,9,8) for 16-bit; (13,17,5) for 32-bit.
- `out_data[i]` = state_i[STATE_W-1 -: OUT_W], driven directly from the state register.
- Global FSM: WARM → RUN.
  - Reset enters WARM if `WARMUP`>0, else RUN.
  - In WARM, every channel advances each cycle and a counter counts `WARMUP` advances. After the last advance, the FSM goes to RUN.
  - In RUN, `out_valid[i]`=1 except in the cycle immediately after a reseed of channel i.
  - Channel i advances only on the out_valid[i] & out_ready[i] handshake.
- Reseed:
  - `reseed_ready` = (FSM==RUN).
  - An accepted request loads state_c ← `reseed_value`. A `reseed_value` of 0 loads channel c's default seed instead.
  - `out_valid[c]` is 0 for the following cycle, then 1.
  - If `reseed_ch` ≥ `NUM_CH`, the request is accepted and has no effect.
- Simultaneous handshake and reseed on the same channel: the reseed wins. The handshaken value counts as consumed, and the state becomes the seed.
- Simultaneous handshake on channel i and reseed of channel j≠i: both take effect independently.
- `out_ready` while `out_valid`=0 is ignored (no advance).
- `out_valid` does not depend combinationally on `out_ready`.

## Timing
- Reset values:
  - all `out_valid`=0, `reseed_ready`=0
  - state_i = default seed i, so `out_data[i]` shows the top bits of the default seed
- Reset is honoured at any time, including mid-warm-up or mid-stream. All channels return to the default seeds and the warm-up restarts.
- Warm-up: `out_valid` and `reseed_ready` rise after exactly `WARMUP` rising edges following reset deassertion. With `WARMUP`=0 they rise on the first edge.
- Advance latency: a handshake at edge k presents the next value on `out_data` after edge k. Back-to-back handshakes yield one value per cycle per channel.
- Reseed latency: a reseed accepted at edge k gives `out_valid[c]`=0 during cycle k+1. Valid data equal to the top bits of the new seed appears from edge k+1.
- Period: every channel has period 2^`STATE_W`−1. State 0 is unreachable.

## Structure
- Package `prng_pkg` holds:
  - the FSM state typedef (`PRNG_WARM`, `PRNG_RUN`)
  - the `GOLD16`/`GOLD32` constants
  - the shift-triplet constants
  - a `default_seed(i)` function
- Sub-module `xorshift_lane`: one channel. It contains the state register (reset via the shared `FF` macro), the next-state logic, the load/advance mux and the post-reseed valid-suppress flop. It is instantiated `NUM_CH` times in a generate loop.
- Top level holds the warm-up counter, the FSM and the reseed decode.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
- `NUM_CH`=1, `STATE_W`=16, `OUT_W`=12, `SEED`=16'h1ACE, `WARMUP`=0: release reset → `out_valid`=1 and `out_data`=12'h1AC. One handshake → `out_data`=12'hEC1 (state 16'hEC17).
- Defaults with `WARMUP`=8: `out_valid` and `reseed_ready` stay 0 for 8 edges and rise on the 8th. `out_data` ch0 then equals the top 12 bits of the state 8 steps from 16'h1ACE, checked against the reference model.
- `NUM_CH`=4 with `out_ready`=4'b0101 held for 100 cycles → channels 0 and 2 advance 100 steps. Channels 1 and 3 hold their initial values. No two channels emit identical sequences.
- Reseed ch2 with 16'h1ACE while ch2 is handshaking → `out_valid[2]`=0 for one cycle, then `out_data[2]`=12'h1AC. Reseed with 0 → ch2 reloads its default seed.
- Drop `rst_n` asynchronously mid-stream and mid-warm-up → outputs are immediately invalid and states return to the defaults. The sequence after release matches the first run cycle-for-cycle.
- `STATE_W`=32, `OUT_W`=16: run 10k random handshakes and reseeds (including `reseed_ch` ≥ `NUM_CH`) against the scoreboard model. State is never 0, and out-of-range reseeds have no effect.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg: shared types, constants and seed helper for the xorshift PRNG bank
`ifndef PRNG_FF
`define PRNG_FF
`define FF(q_, d_, r_) always_ff @(posedge clk or negedge rst_n) if (!rst_n) q_ <= (r_); else q_ <= (d_);
`endif

package prng_pkg;
  typedef enum logic {PRNG_WARM, PRNG_RUN} prng_state_e;
  localparam logic [31:0] GOLD16 = 32'h0000_9E37;
  localparam logic [31:0] GOLD32 = 32'h9E37_79B9;
  localparam int SH16_A = 7;
  localparam int SH16_B = 9;
  localparam int SH16_C = 8;
  localparam int SH32_A = 13;
  localparam int SH32_B = 17;
  localparam int SH32_C = 5;
  // Zero would lock xorshift at zero forever, so it is replaced with 1.
  function automatic logic [31:0] default_seed(int sw, logic [31:0] seed, int i);
    logic [31:0] mask;
    logic [31:0] v;
    mask = sw == 16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    v = (seed ^ (32'(i) * (sw == 16 ? GOLD16 : GOLD32))) & mask;
    return v == '0 ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/xorshift_prng_bank_lane.sv
// xorshift_lane: one PRNG channel with load/advance mux and post-reseed valid suppress
module xorshift_lane
  import prng_pkg::*;
#(
  parameter int STATE_W = 16,
  parameter int OUT_W = 12,
  parameter logic [STATE_W-1:0] DSEED = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               run,
  input  logic               ready,
  input  logic               load,
  input  logic [STATE_W-1:0] load_value,
  output logic               valid,
  output logic [OUT_W-1:0]   data
);
  localparam int A = STATE_W == 16 ? SH16_A : SH32_A;
  localparam int B = STATE_W == 16 ? SH16_B : SH32_B;
  localparam int C = STATE_W == 16 ? SH16_C : SH32_C;
  logic [STATE_W-1:0] state, t, t2, nxt, d;
  logic sup;
  always_comb begin
    t = state ^ (state >> A);
    t2 = t ^ (t << B);
    nxt = t2 ^ (t2 >> C);
    d = load ? (load_value == '0 ? DSEED : load_value) : (step || (valid && ready)) ? nxt : state;
  end
  `FF(state, d, DSEED)
  `FF(sup, load, 1'b0)
  assign valid = run & ~sup;
  assign data = state[STATE_W-1 -: OUT_W];
endmodule

// File: rtl/xorshift_prng_bank.sv
// xorshift_prng_bank: multi-channel xorshift PRNG with warm-up FSM and shared reseed port
module xorshift_prng_bank
  import prng_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int STATE_W = 16,
  parameter int OUT_W = 12,
  parameter logic [STATE_W-1:0] SEED = 16'h1ACE,
  parameter int WARMUP = 8,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  input  logic                    reseed_valid,
  output logic                    reseed_ready,
  input  logic [CW-1:0]           reseed_ch,
  input  logic [STATE_W-1:0]      reseed_value
);
  localparam int WCW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  localparam logic [WCW-1:0] LAST = WCW'(WARMUP - 1);
  if (NUM_CH < 1) begin : g_bad_ch
    $error("NUM_CH must be at least 1");
  end
  if (STATE_W != 16 && STATE_W != 32) begin : g_bad_w
    $error("STATE_W must be 16 or 32");
  end
  if (OUT_W < 1 || OUT_W > STATE_W) begin : g_bad_out
    $error("OUT_W must be within 1..STATE_W");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  if (WARMUP < 0) begin : g_bad_warm
    $error("WARMUP must not be negative");
  end
  prng_state_e fsm;
  logic [WCW-1:0] cnt;
  logic run, acc;
  // run is the registered view of the FSM so valid rises exactly WARMUP edges after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= WARMUP > 0 ? PRNG_WARM : PRNG_RUN;
      cnt <= '0;
      run <= 1'b0;
    end else if (fsm == PRNG_WARM) begin
      cnt <= cnt + WCW'(1);
      if (cnt == LAST) begin
        fsm <= PRNG_RUN;
        run <= 1'b1;
      end
    end else begin
      run <= 1'b1;
    end
  assign reseed_ready = run;
  assign acc = reseed_valid & run;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xorshift_lane #(
      .STATE_W(STATE_W),
      .OUT_W(OUT_W),
      .DSEED(STATE_W'(default_seed(STATE_W, 32'(SEED), i)))
    ) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .step(fsm == PRNG_WARM),
      .run(run),
      .ready(out_ready[i]),
      .load(acc && reseed_ch == CW'(i)),
      .load_value(reseed_value),
      .valid(out_valid[i]),
      .data(out_data[i*OUT_W +: OUT_W])
    );
  end
endmodule
